// File: rtl/codec_audio_data_to_acc_mat.sv
// Avalon-MM slave that buffers CPU-written 24-bit audio samples in a show-ahead FIFO and streams them to AccMat.
// readdata has 1-cycle latency; out_data holds while out_ready is low; an overflowing push is dropped and flagged sticky.
module codec_audio_data_to_acc_mat #(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int LOW_WATER = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [1:0]  i_address,
  input  logic        i_write,
  input  logic [31:0] i_writedata,
  output logic [31:0] o_readdata,
  output logic [23:0] o_out_data,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic        o_irq
);

  localparam logic [AW:0]   LP_DEPTH   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LP_LOW     = (AW+1)'(LOW_WATER);
  localparam logic [AW:0]   LP_CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] LP_PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [23:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_enable;
  logic          r_irq_en;
  logic          r_overflow;
  logic          r_irq;
  logic [31:0]   r_readdata;

  logic          w_push_req;
  logic          w_push_ok;
  logic          w_pop;
  logic          w_ctrl_wr;
  logic          w_flush;
  logic          w_clr_ovf;
  logic          w_empty;
  logic          w_full;
  logic [AW:0]   w_count_next;
  logic          w_enable_next;
  logic          w_irq_en_next;
  logic [31:0]   w_rd_mux;
  logic [15:0]   w_count16;
  logic          w_unused;

  assign w_unused    = ^i_writedata[31:24];
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == LP_DEPTH);
  assign w_count16   = {{(15-AW){1'b0}}, r_count};
  assign o_out_valid = r_enable && !w_empty;
  assign o_out_data  = r_mem[r_rd_ptr];
  assign o_readdata  = r_readdata;
  assign o_irq       = r_irq;

  assign w_pop      = o_out_valid && i_out_ready;
  assign w_push_req = i_write && (i_address == 2'd0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push_ok  = w_push_req && (!w_full || w_pop);
  assign w_ctrl_wr  = i_write && (i_address == 2'd2);
  assign w_flush    = w_ctrl_wr && i_writedata[1];
  assign w_clr_ovf  = w_ctrl_wr && i_writedata[2];

  always_comb begin
    w_count_next = r_count;
    if (w_flush) begin
      w_count_next = '0;
    end else begin
      case ({w_push_ok, w_pop})
        2'b10:   w_count_next = r_count + LP_CNT_ONE;
        2'b01:   w_count_next = r_count - LP_CNT_ONE;
        default: w_count_next = r_count;
      endcase
    end
  end

  always_comb begin
    w_enable_next = r_enable;
    w_irq_en_next = r_irq_en;
    if (w_ctrl_wr) begin
      w_enable_next = i_writedata[0];
      w_irq_en_next = i_writedata[3];
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (i_address)
      2'd0: if (!w_empty) w_rd_mux = {8'h00, r_mem[r_rd_ptr]};
      2'd1: w_rd_mux = {11'b0, r_irq_en, r_enable, r_overflow, w_full, w_empty, w_count16};
      2'd2: w_rd_mux = {28'b0, r_irq_en, 2'b00, r_enable};
      default: w_rd_mux = '0;
    endcase
  end

  // Storage has no reset; stale entries are never visible because count gates every read.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_writedata[23:0];
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_enable   <= 1'b0;
      r_irq_en   <= 1'b0;
      r_overflow <= 1'b0;
      r_irq      <= 1'b0;
      r_readdata <= '0;
    end else begin
      r_readdata <= w_rd_mux;
      r_count    <= w_count_next;
      r_enable   <= w_enable_next;
      r_irq_en   <= w_irq_en_next;
      r_irq      <= w_irq_en_next && w_enable_next && (w_count_next <= LP_LOW);
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push_ok) r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
        if (w_pop)     r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
      end
      // A rejected push beats a clear request landing in the same cycle.
      if (w_push_req && !w_push_ok) r_overflow <= 1'b1;
      else if (w_clr_ovf)           r_overflow <= 1'b0;
    end
  end

endmodule
